mult_booth: RTL and testbench

Multicycle signed 32x32 multiplier using radix-2 Booth recoding. It sits directly upstream of the 32-bit carry-lookahead adder and owns it. Each cycle it drives the adder's A, B and Cin, then consumes the adder's sum and overflow flag to build a 64-bit product. It returns the low 32 bits to the processor's multdiv path, together with a ready pulse and an overflow exception.

---
 rtl/mult_booth_if.sv | 28 ++
 rtl/mult_booth.sv | 145 ++++++++++++++
 tb/tb_mult_booth.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mult_booth_if.sv
// Start/operand and result bundle between the multdiv path and mult_booth.
// master drives the request, slave returns the product.
interface mult_booth_if;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output ctrl_MULT,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  ctrl_MULT,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
        output data_resultRDY
    );
endinterface

// File: rtl/mult_booth.sv
// Multicycle signed 32x32 radix-2 Booth multiplier, 32 steps per product.
// All arithmetic goes through the owned 32-bit carry-lookahead adder.
module mult_booth_cla (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        ovf
);
    logic [31:0] g;
    logic [31:0] p;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic       c;
        logic [3:0] gg;
        logic [3:0] pp;
        logic [4:0] cc;
        c   = cin;
        gg  = '0;
        pp  = '0;
        cc  = '0;
        sum = '0;
        for (int k = 0; k < 8; k++) begin
            gg    = g[4*k +: 4];
            pp    = p[4*k +: 4];
            cc[0] = c;
            cc[1] = gg[0] | (pp[0] & c);
            cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c);
            cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                  | ((&pp[2:0]) & c);
            cc[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                  | ((&pp[3:1]) & gg[0]) | ((&pp) & c);
            sum[4*k +: 4] = pp ^ cc[3:0];
            c = cc[4];
        end
        ovf = (a[31] ~^ b[31]) & (sum[31] ^ a[31]);
    end
endmodule

module mult_booth (
    input  logic          clock,
    input  logic          reset,
    mult_booth_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] m;
    logic [31:0] h;
    logic [31:0] l;
    logic        q;
    logic [4:0]  cnt;
    logic [31:0] res;
    logic        exc;
    logic        rdy;

    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_c;
    logic [31:0] add_s;
    logic        add_o;
    logic [31:0] sum;
    logic        msb;
    logic [31:0] h_n;
    logic [31:0] l_n;

    mult_booth_cla u_add (
        .a   (add_a),
        .b   (add_b),
        .cin (add_c),
        .sum (add_s),
        .ovf (add_o)
    );

    // Adder overflow flips the sign so the 33-bit partial sum shifts in correctly.
    always_comb begin
        add_a = h;
        add_b = m;
        add_c = 1'b0;
        sum   = h;
        msb   = h[31];
        unique case (1'b1)
            (~l[0] & q): begin
                sum = add_s;
                msb = add_s[31] ^ add_o;
            end
            (l[0] & ~q): begin
                add_b = ~m;
                add_c = 1'b1;
                sum   = add_s;
                msb   = add_s[31] ^ add_o;
            end
            default: ;
        endcase
        h_n = {msb, sum[31:1]};
        l_n = {sum[0], l[31:1]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            m     <= '0;
            h     <= '0;
            l     <= '0;
            q     <= 1'b0;
            cnt   <= '0;
            res   <= '0;
            exc   <= 1'b0;
            rdy   <= 1'b0;
        end else if (bus.ctrl_MULT) begin
            state <= RUN;
            m     <= bus.data_operandA;
            h     <= '0;
            l     <= bus.data_operandB;
            q     <= 1'b0;
            cnt   <= '0;
            rdy   <= 1'b0;
        end else begin
            rdy <= 1'b0;
            unique case (state)
                RUN: begin
                    h   <= h_n;
                    l   <= l_n;
                    q   <= l[0];
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= DONE;
                        rdy   <= 1'b1;
                        res   <= l_n;
                        exc   <= (h_n != {32{l_n[31]}});
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_result    = res;
    assign bus.data_exception = exc;
    assign bus.data_resultRDY = rdy;
endmodule

// File: tb/tb_mult_booth.sv
// Directed bench for mult_booth with a queue scoreboard of expected products.
// Expected values come from a 64-bit signed reference multiply.
module tb_mult_booth;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    mult_booth_if bus ();

    mult_booth dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] r;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        longint pr;
        exp_t   e;
        pa  = $signed(a);
        pb  = $signed(b);
        pr  = pa * pb;
        e.r = pr[31:0];
        e.e = (pr != longint'($signed(pr[31:0])));
        return e;
    endfunction

    task automatic go(input logic [31:0] a, input logic [31:0] b,
                      input bit push);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        if (push) sb.push_back(model(a, b));
    endtask

    // Called at the negedge where a start was driven; stops at the RDY negedge.
    task automatic wait_rdy(input string tag, input int exp_at,
                            input bit hold, input logic [31:0] hv);
        int   seen;
        int   bad;
        exp_t e;
        seen = 0;
        bad  = 0;
        for (int i = 1; i <= exp_at + 4 && seen == 0; i++) begin
            @(negedge clock);
            if (i == 1) begin
                bus.ctrl_MULT     = 1'b0;
                bus.data_operandA = $urandom;
                bus.data_operandB = $urandom;
            end
            if (bus.data_resultRDY) seen = i;
            else if (hold && bus.data_result !== hv) bad++;
        end
        chk({tag, "_lat"}, 64'(seen), 64'(exp_at));
        if (hold) chk({tag, "_hold"}, 64'(bad), 64'd0);
        chk({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_res"}, 64'(bus.data_result), 64'(e.r));
            chk({tag, "_exc"}, 64'(bus.data_exception), 64'(e.e));
        end
    endtask

    initial begin
        logic [31:0] ta [7];
        logic [31:0] tb [7];
        int          n;

        ta = '{32'd3, 32'hFFFFFFF9, 32'd6, 32'h80000000,
               32'h80000000, 32'h00010000, 32'h00008000};
        tb = '{32'd5, 32'd6, 32'hFFFFFFF9, 32'h80000000,
               32'hFFFFFFFF, 32'h00010000, 32'hFFFF0000};

        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (2) @(negedge clock);
        chk("rst_res", 64'(bus.data_result), 64'd0);
        chk("rst_exc", 64'(bus.data_exception), 64'd0);
        chk("rst_rdy", 64'(bus.data_resultRDY), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int k = 0; k < 7; k++) begin
            go(ta[k], tb[k], 1'b1);
            wait_rdy($sformatf("op%0d", k), 33, 1'b0, '0);
            @(negedge clock);
            chk($sformatf("op%0d_pulse", k), 64'(bus.data_resultRDY), 64'd0);
        end

        go(32'd3, 32'd5, 1'b0);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 1) bus.ctrl_MULT = 1'b0;
            if (bus.data_resultRDY) n++;
        end
        chk("abort_rdy", 64'(n), 64'd0);
        go(32'd4, 32'd4, 1'b1);
        wait_rdy("restart", 33, 1'b0, '0);
        @(negedge clock);
        chk("restart_pulse", 64'(bus.data_resultRDY), 64'd0);

        go(32'd9, 32'd9, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (i == 1) bus.ctrl_MULT = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mrst_res", 64'(bus.data_result), 64'd0);
        chk("mrst_exc", 64'(bus.data_exception), 64'd0);
        chk("mrst_rdy", 64'(bus.data_resultRDY), 64'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY) n++;
        end
        chk("mrst_norpy", 64'(n), 64'd0);

        go(32'd2, 32'd3, 1'b1);
        wait_rdy("b2b_a", 33, 1'b0, '0);
        go(32'd5, 32'd5, 1'b1);
        wait_rdy("b2b_b", 33, 1'b1, 32'd6);
        @(negedge clock);

        go(32'd7, 32'd7, 1'b0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY) n++;
        end
        bus.ctrl_MULT = 1'b0;
        chk("held_rdy", 64'(n), 64'd0);
        chk("held_res", 64'(bus.data_result), 64'd25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
